// File: rtl/register_file_sb_pkg.sv
// Shared widths and address-width helper for the pipelined register file.
// Defaults match the ISA word and register-count definitions.
package register_file_sb_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int REG_COUNT  = 32;

    // Address width for a register count; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Read, writeback, claim and flush bundle between issue/writeback and the register file.
// Master is the pipeline side; slave is the register file.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int WIDTH    = WORD_WIDTH,
    parameter int DEPTH    = REG_COUNT,
    parameter int NUM_READ = 2
);
    localparam int AW = addr_width(DEPTH);

    logic [NUM_READ*AW-1:0]    readAddr;
    logic [NUM_READ*WIDTH-1:0] readData;
    logic [NUM_READ-1:0]       readBusy;
    logic                      writeEn;
    logic [AW-1:0]             writeAddr;
    logic [WIDTH-1:0]          writeData;
    logic                      claimEn;
    logic [AW-1:0]             claimAddr;
    logic                      flush;
    logic                      anyPending;

    modport master (
        output readAddr, writeEn, writeAddr, writeData, claimEn, claimAddr, flush,
        input  readData, readBusy, anyPending
    );

    modport slave (
        input  readAddr, writeEn, writeAddr, writeData, claimEn, claimAddr, flush,
        output readData, readBusy, anyPending
    );

endinterface

// File: rtl/register_file_sb_reg_scoreboard.sv
// Purpose: per-register pending-write bits with flush < release < claim priority.
// Latency: busy/anyPending combinational from current bits; updates on posedge.
// Backpressure: none; issue stalls on busy externally.
module reg_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_READ*AW-1:0] readAddr,
    input  logic                   writeEn,
    input  logic [AW-1:0]          writeAddr,
    input  logic                   claimEn,
    input  logic [AW-1:0]          claimAddr,
    input  logic                   flush,
    output logic [NUM_READ-1:0]    rawBusy,
    output logic                   anyPending
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Claim is applied last so a producer issued alongside a flush or an
    // older writeback to the same register remains tracked.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end
        if (writeEn) begin
            pending_nxt[writeAddr] = 1'b0;
        end
        if (claimEn) begin
            pending_nxt[claimAddr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        rawBusy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rawBusy[i] = pending[readAddr[i*AW +: AW]];
        end
    end

    assign anyPending = |pending;

endmodule

// File: rtl/register_file_sb.sv
// Purpose: multi-port register file with writeback bypass and pending-write scoreboard.
// Latency: reads and busy are zero-cycle combinational; writes/claims land on posedge.
// Backpressure: none; consumers stall on readBusy.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int WIDTH    = WORD_WIDTH,
    parameter int DEPTH    = REG_COUNT,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_sb_if.slave  bus
);

    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0]    regs [DEPTH];
    logic                wr_ok;
    logic [NUM_READ-1:0] raw_busy;

    assign wr_ok = bus.writeEn && !((ZERO_REG != 0) && (bus.writeAddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.writeAddr] <= bus.writeData;
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .readAddr   (bus.readAddr),
        .writeEn    (bus.writeEn),
        .writeAddr  (bus.writeAddr),
        .claimEn    (bus.claimEn),
        .claimAddr  (bus.claimAddr),
        .flush      (bus.flush),
        .rawBusy    (raw_busy),
        .anyPending (bus.anyPending)
    );

    // Outputs are forced to zero while reset is held so a bypassed write
    // in the reset cycle cannot leak onto readData.
    always_comb begin
        logic [AW-1:0] addr;
        logic          fwd;
        bus.readData = '0;
        bus.readBusy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            addr = bus.readAddr[i*AW +: AW];
            fwd  = (BYPASS != 0) && wr_ok && (bus.writeAddr == addr);
            if (!rst_n || ((ZERO_REG != 0) && (addr == '0))) begin
                bus.readData[i*WIDTH +: WIDTH] = '0;
            end else if (fwd) begin
                bus.readData[i*WIDTH +: WIDTH] = bus.writeData;
            end else begin
                bus.readData[i*WIDTH +: WIDTH] = regs[addr];
            end
            bus.readBusy[i] = raw_busy[i] && !fwd;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboarded bench: one bypassing and one non-bypassing register file driven in lockstep.
module tb_register_file_sb;
    import register_file_sb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_sb_if #(.WIDTH(32), .DEPTH(32), .NUM_READ(2)) bus ();
    register_file_sb_if #(.WIDTH(32), .DEPTH(32), .NUM_READ(2)) nb ();

    register_file_sb #(.BYPASS(1)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    register_file_sb #(.BYPASS(0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(nb));

    assign nb.readAddr  = bus.readAddr;
    assign nb.writeEn   = bus.writeEn;
    assign nb.writeAddr = bus.writeAddr;
    assign nb.writeData = bus.writeData;
    assign nb.claimEn   = bus.claimEn;
    assign nb.claimAddr = bus.claimAddr;
    assign nb.flush     = bus.flush;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ce, input logic [4:0] ca, input logic fl,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.writeEn   = we;
        bus.writeAddr = wa;
        bus.writeData = wd;
        bus.claimEn   = ce;
        bus.claimAddr = ca;
        bus.flush     = fl;
        bus.readAddr  = {ra1, ra0};
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd31);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL reset_rd0 got=%h exp=%h", bus.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[63:32] !== e) begin n_bad++; $display("FAIL reset_rd1 got=%h exp=%h", bus.readData[63:32], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({30'h0, bus.readBusy} !== e) begin n_bad++; $display("FAIL reset_busy got=%b exp=%0d", bus.readBusy, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL reset_any got=%b exp=%0d", bus.anyPending, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (nb.readData !== {e, e}) begin n_bad++; $display("FAIL reset_nb_rd got=%h exp=%h", nb.readData, {e, e}); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(1, 5'd7, 32'hDEADBEEF, 0, 0, 0, 5'd7, 5'd7);
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL byp_rd0 got=%h exp=%h", bus.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[63:32] !== e) begin n_bad++; $display("FAIL byp_rd1 got=%h exp=%h", bus.readData[63:32], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (nb.readData[31:0] !== e) begin n_bad++; $display("FAIL nobyp_same_cycle got=%h exp=%h", nb.readData[31:0], e); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (nb.readData[31:0] !== e) begin n_bad++; $display("FAIL nobyp_next_cycle got=%h exp=%h", nb.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL byp_stored got=%h exp=%h", bus.readData[31:0], e); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(1, 5'd0, 32'h1234, 1, 5'd0, 0, 5'd0, 5'd0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL r0_same_cycle got=%h exp=%h", bus.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (nb.readData[31:0] !== e) begin n_bad++; $display("FAIL r0_nb_same_cycle got=%h exp=%h", nb.readData[31:0], e); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL r0_after got=%h exp=%h", bus.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({30'h0, bus.readBusy} !== e) begin n_bad++; $display("FAIL r0_busy got=%b exp=%0d", bus.readBusy, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL r0_any got=%b exp=%0d", bus.anyPending, e); end
    endtask

    task automatic test_claim_release();
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd3, 0, 5'd3, 5'd3);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.readBusy[0]} !== e) begin n_bad++; $display("FAIL claim_same_cycle_busy got=%b exp=%0d", bus.readBusy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL claim_same_cycle_any got=%b exp=%0d", bus.anyPending, e); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.readBusy[0]} !== e) begin n_bad++; $display("FAIL claim_busy got=%b exp=%0d", bus.readBusy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL claim_any got=%b exp=%0d", bus.anyPending, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, nb.readBusy[1]} !== e) begin n_bad++; $display("FAIL claim_nb_busy got=%b exp=%0d", nb.readBusy[1], e); end
        @(negedge clk);
        drive(1, 5'd3, 32'h55, 0, 0, 0, 5'd3, 5'd3);
        exp_q.push_back(32'h0); exp_q.push_back(32'h55); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.readBusy[0]} !== e) begin n_bad++; $display("FAIL release_fwd_busy got=%b exp=%0d", bus.readBusy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL release_fwd_data got=%h exp=%h", bus.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, nb.readBusy[0]} !== e) begin n_bad++; $display("FAIL release_nb_busy got=%b exp=%0d", nb.readBusy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (nb.readData[31:0] !== e) begin n_bad++; $display("FAIL release_nb_data got=%h exp=%h", nb.readData[31:0], e); end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h55);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL release_any got=%b exp=%0d", bus.anyPending, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({30'h0, nb.readBusy} !== e) begin n_bad++; $display("FAIL release_nb_after got=%b exp=%0d", nb.readBusy, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (nb.readData[31:0] !== e) begin n_bad++; $display("FAIL release_nb_stored got=%h exp=%h", nb.readData[31:0], e); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd3, 0, 5'd3, 5'd3);
        @(negedge clk);
        drive(1, 5'd3, 32'hA5A5A5A5, 1, 5'd3, 0, 5'd3, 5'd3);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL wc_data got=%h exp=%h", bus.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.readBusy[0]} !== e) begin n_bad++; $display("FAIL wc_busy got=%b exp=%0d", bus.readBusy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL wc_any got=%b exp=%0d", bus.anyPending, e); end
        drive(0, 0, 0, 1, 5'd2, 0, 5'd0, 5'd0);
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd4, 0, 5'd0, 5'd0);
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd9, 1, 5'd0, 5'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd2);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.readBusy[0]} !== e) begin n_bad++; $display("FAIL flush_r9 got=%b exp=%0d", bus.readBusy[0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.readBusy[1]} !== e) begin n_bad++; $display("FAIL flush_r2 got=%b exp=%0d", bus.readBusy[1], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL flush_any got=%b exp=%0d", bus.anyPending, e); end
        drive(0, 0, 0, 0, 0, 0, 5'd4, 5'd3);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if ({30'h0, bus.readBusy} !== e) begin n_bad++; $display("FAIL flush_r4_r3 got=%b exp=%0d", bus.readBusy, e); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(1, 5'd10, 32'hFF, 0, 0, 0, 5'd10, 5'd7);
        exp_q.push_back(32'hFF);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL pre_reset_fwd got=%h exp=%h", bus.readData[31:0], e); end
        #1 rst_n = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData !== {e, e}) begin n_bad++; $display("FAIL arst_rd got=%h exp=0", bus.readData); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL arst_any got=%b exp=%0d", bus.anyPending, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (nb.readData !== {e, e}) begin n_bad++; $display("FAIL arst_nb_rd got=%h exp=0", nb.readData); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 5'd10, 5'd7);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[31:0] !== e) begin n_bad++; $display("FAIL post_reset_r10 got=%h exp=%h", bus.readData[31:0], e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.readData[63:32] !== e) begin n_bad++; $display("FAIL post_reset_r7 got=%h exp=%h", bus.readData[63:32], e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'h0, bus.anyPending} !== e) begin n_bad++; $display("FAIL post_reset_any got=%b exp=%0d", bus.anyPending, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({30'h0, bus.readBusy} !== e) begin n_bad++; $display("FAIL post_reset_busy got=%b exp=%0d", bus.readBusy, e); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_claim_release();
        test_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
